// File: rtl/network_interface_if.sv
// network_interface_if: core/router handshake bundle seen by the network interface
interface network_interface_if #(
  parameter int ROUTER_ADDR_WIDTH = 4,
  parameter int NEURON_ID_WIDTH   = 8,
  parameter int FANOUT_WIDTH      = 4
);
  logic [ROUTER_ADDR_WIDTH-1:0] router_addr;
  logic                         spike_valid;
  logic                         spike_ready;
  logic [ROUTER_ADDR_WIDTH-1:0] spike_dest_base;
  logic [FANOUT_WIDTH-1:0]      spike_fanout;
  logic [NEURON_ID_WIDTH-1:0]   spike_neuron_id;
  logic [15:0]                  spike_timestep;
  logic [31:0]                  local_in_packet;
  logic                         local_in_valid;
  logic                         local_in_ready;
  logic [31:0]                  local_out_packet;
  logic                         local_out_valid;
  logic                         local_out_ready;
  logic                         rx_valid;
  logic                         rx_ready;
  logic [ROUTER_ADDR_WIDTH-1:0] rx_src_addr;
  logic [NEURON_ID_WIDTH-1:0]   rx_neuron_id;
  logic [15:0]                  rx_timestep;
  logic                         rx_drop;
  logic [15:0]                  stat_tx_count;
  logic [15:0]                  stat_rx_count;

  modport slave (
    input  router_addr, spike_valid, spike_dest_base, spike_fanout, spike_neuron_id,
           spike_timestep, local_in_ready, local_out_packet, local_out_valid, rx_ready,
    output spike_ready, local_in_packet, local_in_valid, local_out_ready, rx_valid,
           rx_src_addr, rx_neuron_id, rx_timestep, rx_drop, stat_tx_count, stat_rx_count
  );

  modport master (
    output router_addr, spike_valid, spike_dest_base, spike_fanout, spike_neuron_id,
           spike_timestep, local_in_ready, local_out_packet, local_out_valid, rx_ready,
    input  spike_ready, local_in_packet, local_in_valid, local_out_ready, rx_valid,
           rx_src_addr, rx_neuron_id, rx_timestep, rx_drop, stat_tx_count, stat_rx_count
  );
endinterface

// File: rtl/network_interface.sv
// network_interface: spike-to-packet TX fanout and address-filtered RX endpoint; NI_STATS_EN adds handshake counters
module network_interface #(
  parameter int ROUTER_ADDR_WIDTH = 4,
  parameter int NEURON_ID_WIDTH   = 8,
  parameter int TX_DEPTH          = 4,
  parameter int RX_DEPTH          = 4,
  parameter int FANOUT_WIDTH      = 4
) (
  input logic clk,
  input logic rst,
  network_interface_if.slave bus
);
  localparam int W   = ROUTER_ADDR_WIDTH;
  localparam int N   = NEURON_ID_WIDTH;
  localparam int FW  = FANOUT_WIDTH;
  localparam int RW  = W + N + 16;
  localparam int TPW = $clog2(TX_DEPTH);
  localparam int TCW = TPW + 1;
  localparam int RPW = $clog2(RX_DEPTH);
  localparam int RCW = RPW + 1;

  typedef enum logic {IDLE, SEND} state_t;

  state_t         state_q;
  logic           spike_ready_q;
  logic [W-1:0]   base_q;
  logic [FW-1:0]  last_q;
  logic [FW-1:0]  idx_q;
  logic [N-1:0]   id_q;
  logic [15:0]    ts_q;

  logic [31:0]    tx_mem [TX_DEPTH];
  logic [TPW-1:0] tx_wr_q;
  logic [TPW-1:0] tx_rd_q;
  logic [TCW-1:0] tx_cnt_q;
  logic           tx_full;
  logic           tx_empty;
  logic           tx_push;
  logic           tx_pop;
  logic [31:0]    tx_pkt;

  logic [RW-1:0]  rx_mem [RX_DEPTH];
  logic [RPW-1:0] rx_wr_q;
  logic [RPW-1:0] rx_rd_q;
  logic [RCW-1:0] rx_cnt_q;
  logic           rx_full;
  logic           rx_empty;
  logic           rx_acc;
  logic           rx_hit;
  logic           rx_push;
  logic           rx_pop;
  logic [RW-1:0]  rx_word;
  logic [RW-1:0]  rx_head;
  logic           drop_q;

  // FIFO status, handshakes and the outgoing packet image for the current fanout index
  always_comb begin
    tx_full  = tx_cnt_q == TCW'(TX_DEPTH);
    tx_empty = tx_cnt_q == '0;
    tx_push  = (state_q == SEND) && !tx_full;
    tx_pop   = !tx_empty && bus.local_in_ready;
    tx_pkt   = '0;
    tx_pkt[31 -: W]     = base_q + W'(idx_q);
    tx_pkt[31-W -: W]   = bus.router_addr;
    tx_pkt[16+N-1:16]   = id_q;
    tx_pkt[15:0]        = ts_q;
    rx_full  = rx_cnt_q == RCW'(RX_DEPTH);
    rx_empty = rx_cnt_q == '0;
    rx_acc   = bus.local_out_valid && !rx_full;
    rx_hit   = bus.local_out_packet[31 -: W] == bus.router_addr;
    rx_push  = rx_acc && rx_hit;
    rx_pop   = !rx_empty && bus.rx_ready;
    rx_word  = {bus.local_out_packet[31-W -: W], bus.local_out_packet[16+N-1:0]};
    rx_head  = rx_empty ? '0 : rx_mem[rx_rd_q];
  end

  // TX FSM: latch a spike in IDLE, then emit one packet per non-full cycle until the last index
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      spike_ready_q <= 1'b1;
      base_q        <= '0;
      last_q        <= '0;
      idx_q         <= '0;
      id_q          <= '0;
      ts_q          <= '0;
    end else if (state_q == IDLE) begin
      if (bus.spike_valid) begin
        state_q       <= SEND;
        spike_ready_q <= 1'b0;
        base_q        <= bus.spike_dest_base;
        last_q        <= bus.spike_fanout == '0 ? '0 : bus.spike_fanout - FW'(1);
        idx_q         <= '0;
        id_q          <= bus.spike_neuron_id;
        ts_q          <= bus.spike_timestep;
      end
    end else if (tx_push) begin
      idx_q <= idx_q + FW'(1);
      if (idx_q == last_q) begin
        state_q       <= IDLE;
        spike_ready_q <= 1'b1;
      end
    end
  end

  // TX FIFO pointers and occupancy; fullness is judged before any same-cycle pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_wr_q  <= '0;
      tx_rd_q  <= '0;
      tx_cnt_q <= '0;
    end else begin
      tx_wr_q  <= tx_push ? tx_wr_q + TPW'(1) : tx_wr_q;
      tx_rd_q  <= tx_pop ? tx_rd_q + TPW'(1) : tx_rd_q;
      tx_cnt_q <= tx_cnt_q + TCW'(tx_push) - TCW'(tx_pop);
    end
  end

  // TX FIFO storage
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_q] <= tx_pkt;
  end

  // RX FIFO pointers, occupancy and the one-cycle drop pulse for misaddressed packets
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_wr_q  <= '0;
      rx_rd_q  <= '0;
      rx_cnt_q <= '0;
      drop_q   <= 1'b0;
    end else begin
      rx_wr_q  <= rx_push ? rx_wr_q + RPW'(1) : rx_wr_q;
      rx_rd_q  <= rx_pop ? rx_rd_q + RPW'(1) : rx_rd_q;
      rx_cnt_q <= rx_cnt_q + RCW'(rx_push) - RCW'(rx_pop);
      drop_q   <= rx_acc && !rx_hit;
    end
  end

  // RX FIFO storage keeps only the fields the core needs
  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr_q] <= rx_word;
  end

  assign bus.spike_ready     = spike_ready_q;
  assign bus.local_in_valid  = !tx_empty;
  assign bus.local_in_packet = tx_empty ? '0 : tx_mem[tx_rd_q];
  assign bus.local_out_ready = !rx_full;
  assign bus.rx_valid        = !rx_empty;
  assign bus.rx_src_addr     = rx_head[RW-1 -: W];
  assign bus.rx_neuron_id    = rx_head[16+N-1:16];
  assign bus.rx_timestep     = rx_head[15:0];
  assign bus.rx_drop         = drop_q;

`ifdef NI_STATS_EN
  logic [15:0] stat_tx_q;
  logic [15:0] stat_rx_q;

  // Handshake counters, wrapping naturally at 16 bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_tx_q <= '0;
      stat_rx_q <= '0;
    end else begin
      stat_tx_q <= tx_pop ? stat_tx_q + 16'd1 : stat_tx_q;
      stat_rx_q <= rx_pop ? stat_rx_q + 16'd1 : stat_rx_q;
    end
  end

  assign bus.stat_tx_count = stat_tx_q;
  assign bus.stat_rx_count = stat_rx_q;
`else
  assign bus.stat_tx_count = '0;
  assign bus.stat_rx_count = '0;
`endif
endmodule

// File: doc/network_interface.md
Name: network_interface

Overview:
- Local-port endpoint between a neuron core and its mesh router.
- TX path: accepts spike events from the core, expands each into 1..N unicast packets to consecutive destination routers, buffers them, and drives the router's local input port.
- RX path: accepts packets from the router's local output port, filters them on destination address, buffers them, and presents decoded spike fields to the core.

Parameters:
- ROUTER_ADDR_WIDTH, 4, router address width (W).
- NEURON_ID_WIDTH, 8, neuron id width (N). Requires 2W+N+16 <= 32.
- TX_DEPTH, 4, TX FIFO entries; power of two, >= 2.
- RX_DEPTH, 4, RX FIFO entries; power of two, >= 2.
- FANOUT_WIDTH, 4, width of the fanout count.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- router_addr  in  W  this router's mesh address.
- spike_valid  in  1  core spike request.
- spike_ready  out  1  NI can accept a spike.
- spike_dest_base  in  W  first destination router.
- spike_fanout  in  FANOUT_WIDTH  number of destinations; 0 is treated as 1.
- spike_neuron_id  in  N  source neuron.
- spike_timestep  in  16  timestep tag.
- local_in_packet  out  32  packet to router local input.
- local_in_valid  out  1  packet valid.
- local_in_ready  in  1  router accepts.
- local_out_packet  in  32  packet from router local output.
- local_out_valid  in  1  packet valid.
- local_out_ready  out  1  NI accepts.
- rx_valid  out  1  decoded spike available.
- rx_ready  in  1  core consumes.
- rx_src_addr  out  W  source router.
- rx_neuron_id  out  N  source neuron.
- rx_timestep  out  16  timestep tag.
- rx_drop  out  1  one-cycle pulse: misaddressed packet discarded.
- stat_tx_count  out  16  packets sent (see Optional Feature).
- stat_rx_count  out  16  packets delivered to core (see Optional Feature).

Behaviour:
- Packet layout:
  - [31 -: W] destination.
  - [31-W -: W] source (router_addr).
  - [16+N-1:16] neuron id.
  - [15:0] timestep.
  - Any remaining bits are 0.
- Reset values: spike_ready=1, local_in_valid=0, local_in_packet=0, local_out_ready=1, rx_valid=0, all rx_* fields=0, rx_drop=0, stat counters=0. The FSM goes to IDLE and both FIFOs empty.
- A reset asserted mid-operation discards any pending fanout and all buffered packets immediately, with no partial output.
- TX FSM, IDLE state:
  - spike_ready=1.
  - On spike_valid&&spike_ready, latch base, fanout (0 becomes 1), id, timestep; clear index i=0; go to SEND.
- TX FSM, SEND state:
  - spike_ready=0.
  - Each cycle the TX FIFO is not full, push packet with dest=(base+i) mod 2^W, then i++.
  - When i reaches fanout-1 with a push, return to IDLE.
  - When the FIFO is full, stall with no push and no index change.
- TX latency: a spike accepted in cycle T has its first packet on local_in_* in cycle T+2 if the FIFO was empty. Subsequent packets follow one per cycle while local_in_ready=1.
- Back-to-back spikes: IDLE is re-entered the cycle after the last push, so the next spike is accepted then. This costs 1 bubble per spike.
- local_in_valid = TX FIFO not empty; local_in_packet = FIFO head.
  - Pop on local_in_valid&&local_in_ready.
  - Head is held stable while valid&&!ready.
  - Push and pop in the same cycle when full: the push is blocked, since fullness is evaluated before the pop.
- local_out_ready = RX FIFO not full.
- On local_out_valid&&local_out_ready:
  - If dest field == router_addr, push to the RX FIFO.
  - Otherwise accept and discard, and pulse rx_drop for exactly 1 cycle.
- rx_valid = RX FIFO not empty; fields decoded from the head. Pop on rx_valid&&rx_ready. Fields read 0 when empty.
- Simultaneous push and pop on a non-full, non-empty RX FIFO keeps occupancy unchanged. A full FIFO accepts nothing even if a pop occurs the same cycle.
- FIFO pointers wrap modulo depth; full/empty are distinguished by a separate occupancy counter.

Optional Feature:
- Macro: NI_STATS_EN.
- Defined:
  - stat_tx_count increments on each local_in handshake.
  - stat_rx_count increments on each rx handshake.
  - Both are 16-bit, wrap 0xFFFF to 0x0000, and reset to 0.
- Undefined: no counter logic is built, and both stat outputs are constant 0.

Test Plan:
- Reset, then spike dest_base=3, fanout=2, id=0x5A, ts=0x0010, router_addr=1, local_in_ready=1 -> packets 0x315A0010 and 0x415A0010 appear in T+2 and T+3; spike_ready returns to 1.
- Fanout=0 -> exactly one packet is sent.
- dest_base=0xF, fanout=3 -> dests wrap to 0xF, 0x0, 0x1.
- Hold local_in_ready=0, send spike fanout=6 with TX_DEPTH=4 -> 4 packets buffered; FSM stalls in SEND with spike_ready=0; packet 0 is held stable. Release ready -> all 6 packets drain in order.
- router_addr=2:
  - Inject 0x215A0010 -> rx_valid with src=1, id=0x5A, ts=0x10.
  - Inject 0x7.... -> rx_drop pulses for 1 cycle and nothing is queued.
  - Fill RX with rx_ready=0 -> local_out_ready drops after 4 packets.
- Assert rst mid-SEND with 2 packets queued -> local_in_valid is 0 and spike_ready is 1 immediately; no stale packets after release. With NI_STATS_EN, counters read 0.
